// File: rtl/writeback_stage_pkg.sv
// Shared pipeline types for the writeback stage and its load alignment helper.
package writeback_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Bundle consumed by the register file and by decode forwarding.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       data;
    } writeback_signals;

    // Retiring instruction handed over by the memory stage.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       result;
        logic                  is_load;
        logic [2:0]            funct3;
        logic [1:0]            addr_lo;
    } mem_wb_signals;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load data alignment and extension; also flags misaligned or
// illegal-width loads. Kept standalone so the AMO path can reuse it.
module load_align
    import writeback_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;

    // Shift the addressed byte/half down to bit 0, then extend per funct3.
    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = shifted[15:0];
        data    = rdata;
        err     = 1'b0;
        case (funct3)
            LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
            LBU: data = {{(XLEN-8){1'b0}}, byte_v};
            LH: begin
                data = {{(XLEN-16){half_v[15]}}, half_v};
                err  = addr_lo[0];
            end
            LHU: begin
                data = {{(XLEN-16){1'b0}}, half_v};
                err  = addr_lo[0];
            end
            LW:  err = (addr_lo != 2'b00);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires instructions into the register file, waiting
// for the data-memory response on loads, and counts retired instructions.
//
//   state     | meaning
//   IDLE      | ready for a new instruction; loads with same-cycle data complete here
//   WAIT_RESP | load accepted, waiting for dmem_rvalid; upstream is stalled
module writeback_stage #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               mem_valid,
    output logic                               mem_ready,
    input  writeback_stage_pkg::mem_wb_signals mem_in,
    input  logic                               dmem_rvalid,
    input  logic [XLEN-1:0]                    dmem_rdata,
    output writeback_stage_pkg::writeback_signals wb_out,
    output logic                               load_err,
    output logic [INSTRET_W-1:0]               instret
);

    import writeback_stage_pkg::*;

    wb_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;
    logic [2:0]            pend_funct3_q, pend_funct3_d;
    logic [1:0]            pend_addr_lo_q, pend_addr_lo_d;
    writeback_signals      wb_q, wb_d;
    logic                  load_err_q, load_err_d;
    logic [INSTRET_W-1:0]  instret_q, instret_d;

    logic                  accept;
    logic                  resp_done;
    logic [2:0]            align_funct3;
    logic [1:0]            align_addr_lo;
    logic [REG_ADDR_W-1:0] load_rd;
    logic [XLEN-1:0]       align_data;
    logic                  align_err;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    // In IDLE the load is decoded straight from mem_in; after a stall the
    // captured pending fields are used since upstream data may be stale.
    always_comb begin
        accept        = mem_valid & mem_ready;
        align_funct3  = (state_q == IDLE) ? mem_in.funct3  : pend_funct3_q;
        align_addr_lo = (state_q == IDLE) ? mem_in.addr_lo : pend_addr_lo_q;
        load_rd       = (state_q == IDLE) ? mem_in.rd_addr : pend_rd_q;
        resp_done     = (state_q == IDLE) ? (accept & mem_in.is_load & dmem_rvalid)
                                          : dmem_rvalid;
    end

    load_align u_load_align (
        .funct3  (align_funct3),
        .addr_lo (align_addr_lo),
        .rdata   (dmem_rdata),
        .data    (align_data),
        .err     (align_err)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: only a load without same-cycle data stalls.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept && mem_in.is_load && !dmem_rvalid) state_d = WAIT_RESP;
            WAIT_RESP: if (dmem_rvalid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        mem_ready = (state_q == IDLE);
    end

    // Writeback, error pulse, retire counter and pending-load capture.
    always_comb begin
        pend_rd_d      = pend_rd_q;
        pend_funct3_d  = pend_funct3_q;
        pend_addr_lo_d = pend_addr_lo_q;
        wb_d.rd_addr   = '0;
        wb_d.data      = wb_q.data;
        load_err_d     = 1'b0;
        instret_d      = instret_q;

        if (state_q == IDLE && accept && mem_in.is_load && !dmem_rvalid) begin
            pend_rd_d      = mem_in.rd_addr;
            pend_funct3_d  = mem_in.funct3;
            pend_addr_lo_d = mem_in.addr_lo;
        end

        if (accept && !mem_in.is_load) begin
            wb_d.rd_addr = mem_in.rd_addr;
            wb_d.data    = mem_in.result;
            instret_d    = instret_q + INSTRET_ONE;
        end else if (resp_done) begin
            if (align_err) begin
                load_err_d = 1'b1;
            end else begin
                wb_d.rd_addr = load_rd;
                wb_d.data    = align_data;
                instret_d    = instret_q + INSTRET_ONE;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_rd_q      <= '0;
            pend_funct3_q  <= '0;
            pend_addr_lo_q <= '0;
            wb_q           <= '0;
            load_err_q     <= 1'b0;
            instret_q      <= '0;
        end else begin
            pend_rd_q      <= pend_rd_d;
            pend_funct3_q  <= pend_funct3_d;
            pend_addr_lo_q <= pend_addr_lo_d;
            wb_q           <= wb_d;
            load_err_q     <= load_err_d;
            instret_q      <= instret_d;
        end
    end

    assign wb_out   = wb_q;
    assign load_err = load_err_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage. Inputs change on the falling edge and
// outputs are sampled on the following falling edge.
module tb_writeback_stage;

    import writeback_stage_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mem_valid;
    logic             mem_ready;
    mem_wb_signals    mem_in;
    logic             dmem_rvalid;
    logic [31:0]      dmem_rdata;
    writeback_signals wb_out;
    logic             load_err;
    logic [63:0]      instret;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .INSTRET_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_in      (mem_in),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .wb_out      (wb_out),
        .load_err    (load_err),
        .instret     (instret)
    );

    task automatic drive_idle();
        mem_valid   = 1'b0;
        mem_in      = '0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        n_vec++; if (wb_out.rd_addr !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", wb_out.rd_addr); end
        n_vec++; if (wb_out.data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", wb_out.data); end
        n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL reset_load_err: got %b want 0", load_err); end
        n_vec++; if (instret !== 64'd0) begin n_err++; $display("FAIL reset_instret: got %0d want 0", instret); end
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", mem_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_non_load();
        mem_valid      = 1'b1;
        mem_in.rd_addr = 5'd5;
        mem_in.result  = 32'h1234_5678;
        mem_in.is_load = 1'b0;
        @(negedge clk);
        drive_idle();
        n_vec++; if (wb_out.rd_addr !== 5'd5) begin n_err++; $display("FAIL nonload_rd: got %0d want 5", wb_out.rd_addr); end
        n_vec++; if (wb_out.data !== 32'h1234_5678) begin n_err++; $display("FAIL nonload_data: got %h want 12345678", wb_out.data); end
        n_vec++; if (instret !== 64'd1) begin n_err++; $display("FAIL nonload_instret: got %0d want 1", instret); end
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL nonload_ready: got %b want 1", mem_ready); end
        @(negedge clk);
        n_vec++; if (wb_out.rd_addr !== 5'd0) begin n_err++; $display("FAIL idle_rd: got %0d want 0", wb_out.rd_addr); end
        n_vec++; if (wb_out.data !== 32'h1234_5678) begin n_err++; $display("FAIL idle_data_hold: got %h want 12345678", wb_out.data); end
    endtask

    task automatic test_lb_lbu();
        mem_valid      = 1'b1;
        mem_in.rd_addr = 5'd9;
        mem_in.is_load = 1'b1;
        mem_in.funct3  = 3'b000;
        mem_in.addr_lo = 2'd2;
        dmem_rvalid    = 1'b1;
        dmem_rdata     = 32'h0080_0000;
        @(negedge clk);
        n_vec++; if (wb_out.rd_addr !== 5'd9) begin n_err++; $display("FAIL lb_rd: got %0d want 9", wb_out.rd_addr); end
        n_vec++; if (wb_out.data !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h want ffffff80", wb_out.data); end
        n_vec++; if (instret !== 64'd2) begin n_err++; $display("FAIL lb_instret: got %0d want 2", instret); end
        mem_in.rd_addr = 5'd10;
        mem_in.funct3  = 3'b100;
        @(negedge clk);
        drive_idle();
        n_vec++; if (wb_out.rd_addr !== 5'd10) begin n_err++; $display("FAIL lbu_rd: got %0d want 10", wb_out.rd_addr); end
        n_vec++; if (wb_out.data !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_data: got %h want 00000080", wb_out.data); end
        n_vec++; if (instret !== 64'd3) begin n_err++; $display("FAIL lbu_instret: got %0d want 3", instret); end
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL lbu_ready: got %b want 1", mem_ready); end
    endtask

    task automatic test_lhu_late();
        mem_valid      = 1'b1;
        mem_in.rd_addr = 5'd12;
        mem_in.is_load = 1'b1;
        mem_in.funct3  = 3'b101;
        mem_in.addr_lo = 2'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL lhu_stall_ready[%0d]: got %b want 0", k, mem_ready); end
            n_vec++; if (wb_out.rd_addr !== 5'd0) begin n_err++; $display("FAIL lhu_stall_rd[%0d]: got %0d want 0", k, wb_out.rd_addr); end
            if (k == 2) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = 32'hBEEF_0000;
            end
        end
        @(negedge clk);
        drive_idle();
        n_vec++; if (wb_out.rd_addr !== 5'd12) begin n_err++; $display("FAIL lhu_rd: got %0d want 12", wb_out.rd_addr); end
        n_vec++; if (wb_out.data !== 32'h0000_BEEF) begin n_err++; $display("FAIL lhu_data: got %h want 0000beef", wb_out.data); end
        n_vec++; if (instret !== 64'd4) begin n_err++; $display("FAIL lhu_instret: got %0d want 4", instret); end
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL lhu_ready_after: got %b want 1", mem_ready); end
    endtask

    task automatic test_load_errors();
        mem_valid      = 1'b1;
        mem_in.rd_addr = 5'd7;
        mem_in.is_load = 1'b1;
        mem_in.funct3  = 3'b010;
        mem_in.addr_lo = 2'd1;
        dmem_rvalid    = 1'b1;
        dmem_rdata     = 32'h5555_AAAA;
        @(negedge clk);
        drive_idle();
        n_vec++; if (load_err !== 1'b1) begin n_err++; $display("FAIL lw_mis_err: got %b want 1", load_err); end
        n_vec++; if (wb_out.rd_addr !== 5'd0) begin n_err++; $display("FAIL lw_mis_rd: got %0d want 0", wb_out.rd_addr); end
        n_vec++; if (instret !== 64'd4) begin n_err++; $display("FAIL lw_mis_instret: got %0d want 4", instret); end
        @(negedge clk);
        n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL lw_mis_pulse_end: got %b want 0", load_err); end
        // illegal funct3 through the stalled path
        mem_valid      = 1'b1;
        mem_in.rd_addr = 5'd9;
        mem_in.is_load = 1'b1;
        mem_in.funct3  = 3'b111;
        mem_in.addr_lo = 2'd0;
        @(negedge clk);
        mem_valid   = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        @(negedge clk);
        drive_idle();
        n_vec++; if (load_err !== 1'b1) begin n_err++; $display("FAIL illegal_err: got %b want 1", load_err); end
        n_vec++; if (wb_out.rd_addr !== 5'd0) begin n_err++; $display("FAIL illegal_rd: got %0d want 0", wb_out.rd_addr); end
        n_vec++; if (instret !== 64'd4) begin n_err++; $display("FAIL illegal_instret: got %0d want 4", instret); end
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL illegal_ready: got %b want 1", mem_ready); end
    endtask

    task automatic test_reset_in_wait();
        mem_valid      = 1'b1;
        mem_in.rd_addr = 5'd3;
        mem_in.is_load = 1'b1;
        mem_in.funct3  = 3'b010;
        mem_in.addr_lo = 2'd0;
        @(negedge clk);
        drive_idle();
        n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rstwait_pre_ready: got %b want 0", mem_ready); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rstwait_ready: got %b want 1", mem_ready); end
        n_vec++; if (instret !== 64'd0) begin n_err++; $display("FAIL rstwait_instret: got %0d want 0", instret); end
        n_vec++; if (wb_out.data !== 32'h0) begin n_err++; $display("FAIL rstwait_data: got %h want 0", wb_out.data); end
        @(negedge clk);
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_1111;
        @(negedge clk);
        drive_idle();
        n_vec++; if (wb_out.rd_addr !== 5'd0) begin n_err++; $display("FAIL late_rvalid_rd: got %0d want 0", wb_out.rd_addr); end
        n_vec++; if (instret !== 64'd0) begin n_err++; $display("FAIL late_rvalid_instret: got %0d want 0", instret); end
        n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL late_rvalid_err: got %b want 0", load_err); end
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL late_rvalid_ready: got %b want 1", mem_ready); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            mem_valid      = 1'b1;
            mem_in.rd_addr = 5'(i);
            mem_in.result  = 32'h100 + 32'(i);
            mem_in.is_load = 1'b0;
            n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, mem_ready); end
            @(negedge clk);
            n_vec++; if (wb_out.rd_addr !== 5'(i)) begin n_err++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", i, wb_out.rd_addr, i); end
            n_vec++; if (wb_out.data !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, wb_out.data, 32'h100 + 32'(i)); end
        end
        drive_idle();
        n_vec++; if (instret !== 64'd4) begin n_err++; $display("FAIL b2b_instret: got %0d want 4", instret); end
    endtask

    task automatic test_align_table();
        logic [2:0]  f3  [5] = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b010};
        logic [1:0]  alo [5] = '{2'd0, 2'd0, 2'd3, 2'd1, 2'd0};
        logic [31:0] rd_w[5] = '{32'h1234_8001, 32'h1234_8001, 32'h7F00_0000, 32'h0000_AB00, 32'hCAFE_BABE};
        logic [31:0] exp [5] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_007F, 32'h0000_00AB, 32'hCAFE_BABE};
        for (int i = 0; i < 5; i++) begin
            mem_valid      = 1'b1;
            mem_in.rd_addr = 5'(20 + i);
            mem_in.is_load = 1'b1;
            mem_in.funct3  = f3[i];
            mem_in.addr_lo = alo[i];
            dmem_rvalid    = 1'b1;
            dmem_rdata     = rd_w[i];
            @(negedge clk);
            n_vec++; if (wb_out.data !== exp[i]) begin n_err++; $display("FAIL align_data[%0d]: got %h want %h", i, wb_out.data, exp[i]); end
            n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL align_err[%0d]: got %b want 0", i, load_err); end
        end
        drive_idle();
        n_vec++; if (instret !== 64'd9) begin n_err++; $display("FAIL align_instret: got %0d want 9", instret); end
    endtask

    initial begin
        test_reset();
        test_non_load();
        test_lb_lbu();
        test_lhu_late();
        test_load_errors();
        test_reset_in_wait();
        test_back_to_back();
        test_align_table();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
